// File: rtl/frame_buffer_reader.sv
// ---------------------------------------------------------------------------
// frame_buffer_reader
//
// Streams one video frame out of a BRAM read port as a valid/ready pixel
// stream with start-of-frame, end-of-line and end-of-frame markers.
//
// Build option:
//   FB_READER_VFLIP_EN - when defined, lines are fetched bottom-up
//                        (vertical flip). out_sof/out_eof still mark the
//                        first and last pixels streamed.
//
// Parameters:
//   WIDTH   pixels per line
//   HEIGHT  lines per frame
//   ADDR_W  BRAM read-address width (WIDTH*HEIGHT must fit)
//   DATA_W  pixel width
//
// Ports:
//   clk        sole clock, also clocks the BRAM read port
//   rst_n      synchronous active-low reset
//   start      one-cycle request to stream a frame (ignored while busy)
//   bram_en    BRAM read enable
//   bram_addr  BRAM read address, holds its last value while bram_en=0
//   bram_dout  BRAM read data, valid one clock after bram_en
//   out_data   streamed pixel
//   out_valid  out_data is valid
//   out_ready  sink accepts the pixel (transfer on out_valid & out_ready)
//   out_sof    marks pixel (0,0) of the streamed frame
//   out_eol    marks the last pixel of each line
//   out_eof    marks the last pixel of the frame
//   busy       high from an accepted start until the final transfer
//   done       one-cycle pulse in the cycle after the final transfer
// ---------------------------------------------------------------------------
module frame_buffer_reader #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof,
    output logic              busy,
    output logic              done
);

    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int ENT_W = DATA_W + 3;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);

`ifdef FB_READER_VFLIP_EN
    // Flipped frames begin at the first pixel of the bottom line.
    localparam logic [ADDR_W-1:0] BASE_FIRST = ADDR_W'((HEIGHT - 1) * WIDTH);
`else
    localparam logic [ADDR_W-1:0] BASE_FIRST = '0;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state;

    // Fetch position: col/row count in stream order, row_base is the BRAM
    // address of the first pixel of the line currently being fetched.
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] last_addr;

    // One read is in flight for exactly one cycle; its markers travel with it.
    logic              inflight;
    logic [2:0]        inflight_mk;

    // Two-entry FIFO, each entry is {pixel, sof, eol, eof}.
    logic [ENT_W-1:0]  fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;

    logic              start_acc;
    logic              fifo_valid;
    logic [ENT_W-1:0]  head;
    logic              pop;
    logic [2:0]        pending;
    logic [ADDR_W-1:0] issue_addr;
    logic              col_last;
    logic              row_last;
    logic              issue_last;
    logic              issue_sof;
    logic              issue_eol;
    logic              issue_eof;
    logic              final_xfer;

    // Handshake bookkeeping. A read is only launched when the slots already
    // committed (FIFO entries plus the read in flight, less the entry leaving
    // this cycle) leave room, so returning data always finds a free entry.
    always_comb begin
        start_acc  = (state == ST_IDLE) && start;
        fifo_valid = (fifo_cnt != 2'd0);
        head       = fifo_mem[rd_ptr];
        pop        = fifo_valid && out_ready;
        pending    = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
        bram_en    = (state == ST_READ) && (pending < 3'd2);
    end

    // Address and marker generation for the pixel about to be fetched.
    // Markers follow stream order, not the BRAM address, so a flipped frame
    // still flags its first and last streamed pixel.
    always_comb begin
        issue_addr = row_base + ADDR_W'(col);
        col_last   = (col == COL_LAST);
        row_last   = (row == ROW_LAST);
        issue_last = col_last && row_last;
        issue_sof  = (col == '0) && (row == '0);
        issue_eol  = col_last;
        issue_eof  = issue_last;
    end

    // The address port shows the live address while reading and otherwise
    // keeps the last address actually issued.
    always_comb begin
        bram_addr = bram_en ? issue_addr : last_addr;
    end

    // Output stage is the FIFO head; everything is forced to zero while the
    // FIFO is empty so idle and post-reset outputs are clean.
    always_comb begin
        out_valid  = fifo_valid;
        out_data   = fifo_valid ? head[ENT_W-1:3] : '0;
        out_sof    = fifo_valid && head[2];
        out_eol    = fifo_valid && head[1];
        out_eof    = fifo_valid && head[0];
        final_xfer = pop && head[0];
        busy       = (state != ST_IDLE);
    end

    // Frame control: IDLE waits for start, READ issues every address once,
    // DRAIN waits for the last pixel to leave through the stream port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (bram_en && issue_last) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (final_xfer) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Fetch counters. Column advances on every issued read; at the end of
    // a line the column wraps and row_base steps one line down (or up when
    // flipped). After the last pixel everything returns to the frame origin
    // so the next frame starts clean without extra logic on start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            row_base  <= BASE_FIRST;
            last_addr <= '0;
        end else if (start_acc) begin
            col      <= '0;
            row      <= '0;
            row_base <= BASE_FIRST;
        end else if (bram_en) begin
            last_addr <= issue_addr;
            if (issue_last) begin
                col      <= '0;
                row      <= '0;
                row_base <= BASE_FIRST;
            end else if (col_last) begin
                col <= '0;
                row <= row + 1'b1;
`ifdef FB_READER_VFLIP_EN
                row_base <= row_base - LINE_STEP;
`else
                row_base <= row_base + LINE_STEP;
`endif
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Track the read in flight so its data and markers can be written into
    // the FIFO when the BRAM returns it next cycle. Reset drops it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            inflight_mk <= 3'b000;
        end else begin
            inflight    <= bram_en;
            inflight_mk <= {issue_sof, issue_eol, issue_eof};
        end
    end

    // Two-entry FIFO. Entries are only overwritten on push, so the head stays
    // stable while the sink stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (inflight) begin
                fifo_mem[wr_ptr] <= {bram_dout, inflight_mk};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_reader
//
// Scoreboard bench for frame_buffer_reader with a 4x3 frame. A simple BRAM
// model returns addr[7:0] one clock after each enable. Expected addresses and
// pixels are queued when a frame is requested; a monitor on the falling edge
// pops and compares whenever the DUT issues a read or transfers a pixel.
// ---------------------------------------------------------------------------
module tb_frame_buffer_reader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 17;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sof;
    logic          out_eol;
    logic          out_eof;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [AW-1:0]   addr_q[$];
    logic [DW+2:0]   pix_q[$];

    int first_en_cyc    = -1;
    int first_valid_cyc = -1;
    int done_cyc        = -1;
    int en_count        = 0;

    logic          stalled = 1'b0;
    logic [DW+2:0] held    = '0;

    logic          toggle_mode = 1'b0;
    int            phase       = 0;
    logic [3:0]    ready_pat   = 4'b1001;

    frame_buffer_reader #(
        .WIDTH (W),
        .HEIGHT(H),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bram_en  (bram_en),
        .bram_addr(bram_addr),
        .bram_dout(bram_dout),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sof  (out_sof),
        .out_eol  (out_eol),
        .out_eof  (out_eof),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: data is the low byte of the address, one clock later.
    initial bram_dout = '0;
    always @(posedge clk) begin
        if (bram_en) bram_dout <= bram_addr[7:0];
    end

    // Sink ready pattern 1,0,0,1 repeating while toggle_mode is set.
    always @(posedge clk) begin
        #2;
        if (toggle_mode) begin
            out_ready = ready_pat[phase];
            phase     = (phase + 1) % 4;
        end
    end

    function automatic logic [AW-1:0] expAddr(input int k);
        int r;
        int c;
        r = k / W;
        c = k % W;
`ifdef FB_READER_VFLIP_EN
        return AW'((H - 1 - r) * W + c);
`else
        return AW'(r * W + c);
`endif
    endfunction

    function automatic logic [DW+2:0] expPix(input int k);
        logic [AW-1:0] a;
        a = expAddr(k);
        return {a[7:0], (k == 0), ((k % W) == W - 1), (k == W * H - 1)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue expectations for a frame, then pulse start for one cycle.
    task automatic applyStimulus(input int n_pix, input int n_addr, output int t0);
        for (int k = 0; k < n_addr; k++) addr_q.push_back(expAddr(k));
        for (int k = 0; k < n_pix; k++)  pix_q.push_back(expPix(k));
        first_en_cyc    = -1;
        first_valid_cyc = -1;
        done_cyc        = -1;
        start = 1'b1;
        t0    = cyc;
        waitCycles(1);
        start = 1'b0;
    endtask

    task automatic waitDone(input int bound, input string name);
        int i;
        i = 0;
        while (done_cyc < 0 && i < bound) begin
            waitCycles(1);
            i++;
        end
        if (done_cyc < 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_timeout: got=no_done expected=done within %0d cycles", name, bound);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, "_bram_en"},   32'(bram_en),   32'd0);
        checkOutput({name, "_busy"},      32'(busy),      32'd0);
        checkOutput({name, "_done"},      32'(done),      32'd0);
        checkOutput({name, "_sof"},       32'(out_sof),   32'd0);
        checkOutput({name, "_eol"},       32'(out_eol),   32'd0);
        checkOutput({name, "_eof"},       32'(out_eof),   32'd0);
        checkOutput({name, "_bram_addr"}, 32'(bram_addr), 32'd0);
        checkOutput({name, "_out_data"},  32'(out_data),  32'd0);
    endtask

    // Monitor: compares issued addresses and transferred pixels against the
    // scoreboard, and checks that a stalled pixel is held unchanged.
    always @(negedge clk) begin
        logic [AW-1:0]   ea;
        logic [DW+2:0]   ep;
        if (rst_n) begin
            if (bram_en) begin
                en_count++;
                if (first_en_cyc < 0) first_en_cyc = cyc;
                if (addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL addr_extra: got=%0d expected=none", bram_addr);
                end else begin
                    ea = addr_q.pop_front();
                    checkOutput("bram_addr", 32'(bram_addr), 32'(ea));
                end
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stalled) begin
                checkOutput("stall_hold", 32'({out_valid, out_data, out_sof, out_eol, out_eof}),
                            32'({1'b1, held}));
            end
            if (out_valid && out_ready) begin
                if (pix_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL pix_extra: got=%0d expected=none", out_data);
                end else begin
                    ep = pix_q.pop_front();
                    checkOutput("pixel", 32'({out_data, out_sof, out_eol, out_eof}), 32'(ep));
                end
            end
            stalled = out_valid && !out_ready;
            held    = {out_data, out_sof, out_eol, out_eof};
            if (done) done_cyc = cyc;
        end else begin
            stalled = 1'b0;
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int t1;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        waitCycles(3);

        $display("[TB] reset state");
        checkAllZero("reset");
        rst_n = 1'b1;
        waitCycles(2);

        $display("[TB] frame with sink always ready");
        applyStimulus(W * H, W * H, t0);
        waitDone(100, "frame1");
        checkOutput("frame1_first_en",    32'(first_en_cyc - t0),    32'd1);
        checkOutput("frame1_first_valid", 32'(first_valid_cyc - t0), 32'd3);
        checkOutput("frame1_done",        32'(done_cyc - t0),        32'd15);
        checkOutput("frame1_busy_after",  32'(busy),                 32'd0);
        waitCycles(2);

        $display("[TB] frame with ready toggling 1,0,0,1");
        phase       = 0;
        toggle_mode = 1'b1;
        applyStimulus(W * H, W * H, t0);
        waitDone(200, "toggle");
        toggle_mode = 1'b0;
        out_ready   = 1'b1;
        waitCycles(2);

        $display("[TB] frame with sink stalled for 10 cycles");
        out_ready = 1'b0;
        en_count  = 0;
        applyStimulus(W * H, W * H, t0);
        waitCycles(9);
        checkOutput("stall_en_count", 32'(en_count),  32'd2);
        checkOutput("stall_valid",    32'(out_valid), 32'd1);
        checkOutput("stall_sof",      32'(out_sof),   32'd1);
        checkOutput("stall_busy",     32'(busy),      32'd1);
        out_ready = 1'b1;
        waitDone(200, "stall");
        waitCycles(2);

        $display("[TB] start during frame ignored, start on done restarts");
        applyStimulus(W * H, W * H, t0);
        waitCycles(4);
        start = 1'b1;
        waitCycles(1);
        start = 1'b0;
        while (cyc < t0 + 15) waitCycles(1);
        checkOutput("restart_done_pulse", 32'(done), 32'd1);
        checkOutput("restart_busy_low",   32'(busy), 32'd0);
        for (int k = 0; k < W * H; k++) addr_q.push_back(expAddr(k));
        for (int k = 0; k < W * H; k++) pix_q.push_back(expPix(k));
        start = 1'b1;
        t1    = cyc;
        waitCycles(1);
        start           = 1'b0;
        done_cyc        = -1;
        first_en_cyc    = -1;
        first_valid_cyc = -1;
        waitDone(100, "restart");
        checkOutput("restart_first_en", 32'(first_en_cyc - t1), 32'd1);
        checkOutput("restart_done",     32'(done_cyc - t1),     32'd15);
        waitCycles(2);

        $display("[TB] reset mid-frame at pixel 6");
        applyStimulus(6, 8, t0);
        waitCycles(8);
        checkOutput("midrst_pixel6", 32'({out_valid, out_data}), 32'({1'b1, 8'd6}));
        rst_n = 1'b0;
        waitCycles(1);
        checkAllZero("midrst");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            waitCycles(1);
            checkOutput("midrst_quiet_valid", 32'(out_valid), 32'd0);
            checkOutput("midrst_quiet_done",  32'(done),      32'd0);
        end
        checkOutput("midrst_no_done_seen", 32'(done_cyc < 0), 32'd1);
        applyStimulus(W * H, W * H, t0);
        waitDone(100, "after_rst");
        checkOutput("after_rst_done", 32'(done_cyc - t0), 32'd15);
        waitCycles(3);

        checkOutput("addr_q_empty", 32'(addr_q.size()), 32'd0);
        checkOutput("pix_q_empty",  32'(pix_q.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
